// File: rtl/asic_mmio_bridge.sv
// Bridges a valid/ready MMIO request/response channel onto the accelerator wrapper's
// single-cycle chip-select/address/we strobe bus with its one-cycle registered read data.
module asic_mmio_bridge #(
    parameter int NUM_CHIPS  = 2,
    parameter int ENDIAN_BIT = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        asic_we,
    output logic        asic_endian,
    output logic [6:0]  asic_chip,
    output logic [7:0]  asic_address,
    output logic [31:0] asic_wdata,
    input  logic [31:0] asic_rdata,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a clock edge where req_valid && req_ready;
    // a response transfers on an edge where resp_valid && resp_ready. Once a side
    // raises valid its payload stays stable until the transfer edge.

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    localparam logic [7:0] LP_NUM_CHIPS = 8'(NUM_CHIPS);

    state_t      r_state;
    state_t      w_next;
    logic        r_we;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_asic_we;
    logic        r_asic_endian;
    logic [6:0]  r_asic_chip;
    logic [7:0]  r_asic_address;
    logic [31:0] r_asic_wdata;

    logic        w_accept;
    logic [6:0]  w_chip;
    logic        w_dec_err;
    logic        w_unused_addr;

    assign w_chip        = req_addr[16:10];
    assign w_unused_addr = ^req_addr;
    assign w_accept      = req_valid && req_ready;

    // Any decode fault short-circuits straight to a response; the wrapper never sees it.
    assign w_dec_err = (req_addr[1:0] != 2'b00)
                    || (w_chip == 7'd0)
                    || ({1'b0, w_chip} >= LP_NUM_CHIPS)
                    || (req_we && (req_be != 4'hF));

    always_comb begin
        w_next     = r_state;
        req_ready  = (r_state == S_IDLE) && !rst;
        resp_valid = (r_state == S_RESP);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_dec_err ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_RESP;
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_we           <= 1'b0;
            r_rdata        <= 32'd0;
            r_err          <= 1'b0;
            r_asic_we      <= 1'b0;
            r_asic_endian  <= 1'b0;
            r_asic_chip    <= 7'd0;
            r_asic_address <= 8'd0;
            r_asic_wdata   <= 32'd0;
        end else begin
            r_state        <= w_next;
            r_asic_we      <= 1'b0;
            r_asic_endian  <= 1'b0;
            r_asic_chip    <= 7'd0;
            r_asic_address <= 8'd0;
            r_asic_wdata   <= 32'd0;
            if ((r_state == S_IDLE) && w_accept) begin
                r_we <= req_we;
                if (w_dec_err) begin
                    r_err   <= 1'b1;
                    r_rdata <= 32'd0;
                end else begin
                    // Loaded on the accept edge so the bus is live for exactly the ISSUE cycle.
                    r_asic_we      <= req_we;
                    r_asic_endian  <= req_addr[ENDIAN_BIT];
                    r_asic_chip    <= w_chip;
                    r_asic_address <= req_addr[9:2];
                    r_asic_wdata   <= req_wdata;
                end
            end
            if (r_state == S_CAPTURE) begin
                r_rdata <= r_we ? 32'd0 : asic_rdata;
                r_err   <= 1'b0;
            end
        end
    end

    assign resp_rdata   = r_rdata;
    assign resp_err     = r_err;
    assign asic_we      = r_asic_we;
    assign asic_endian  = r_asic_endian;
    assign asic_chip    = r_asic_chip;
    assign asic_address = r_asic_address;
    assign asic_wdata   = r_asic_wdata;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_asic_mmio_bridge.sv
// Bench for asic_mmio_bridge: wrapper read-data model, latency-based transaction model
// checked every cycle, directed literal cases and randomized traffic.
module tb_asic_mmio_bridge;

    localparam int NUM_CHIPS = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        asic_we;
    logic        asic_endian;
    logic [6:0]  asic_chip;
    logic [7:0]  asic_address;
    logic [31:0] asic_wdata;
    logic [31:0] asic_rdata;
    logic [1:0]  dbg_state_unused;

    asic_mmio_bridge #(.NUM_CHIPS(NUM_CHIPS), .ENDIAN_BIT(17)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .asic_we(asic_we), .asic_endian(asic_endian), .asic_chip(asic_chip),
        .asic_address(asic_address), .asic_wdata(asic_wdata),
        .asic_rdata(asic_rdata), .dbg_state(dbg_state_unused)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // wrapper model: registered read data, garbage whenever no read is presented
    logic [31:0] rd_mem [256];
    always_ff @(posedge clk) begin
        asic_rdata <= (asic_chip != 7'd0 && !asic_we) ? rd_mem[asic_address] : $urandom;
    end

    // transaction model: one outstanding request, timed from its accept edge
    logic        live = 1'b0;
    logic        m_busy = 1'b0;
    int          m_t0 = 0;
    logic        m_err, m_we, m_end;
    logic [6:0]  m_chip;
    logic [7:0]  m_aidx;
    logic [31:0] m_wd, m_rd;
    int          acc_q[$];

    function automatic logic exp_resp_valid();
        return m_busy && ((cyc - m_t0) >= (m_err ? 1 : 3));
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                live   = 1'b1;
                m_busy = 1'b0;
            end else if (live) begin
                if (exp_resp_valid() && resp_ready) begin
                    m_busy = 1'b0;
                end else if (!m_busy && req_valid) begin
                    m_chip = req_addr[16:10];
                    m_err  = (req_addr[1:0] != 2'b00) || (m_chip == 7'd0) ||
                             (int'(m_chip) >= NUM_CHIPS) || (req_we && req_be != 4'hF);
                    m_we   = req_we;
                    m_aidx = req_addr[9:2];
                    m_end  = req_addr[17];
                    m_wd   = req_wdata;
                    m_rd   = m_err ? 32'd0 : (req_we ? 32'd0 : rd_mem[req_addr[9:2]]);
                    m_t0   = cyc;
                    m_busy = 1'b1;
                    acc_q.push_back(cyc);
                end
            end
            cyc++;
        end
    end

    // compare process: every cycle once the first reset edge has been seen
    initial begin
        logic e_iss;
        logic e_rv;
        forever begin
            @(negedge clk);
            if (live) begin
                e_rv  = exp_resp_valid();
                e_iss = m_busy && !m_err && ((cyc - m_t0) == 1);
                chk("req_ready",    32'(req_ready),    32'(!m_busy && !rst));
                chk("resp_valid",   32'(resp_valid),   32'(e_rv));
                chk("asic_we",      32'(asic_we),      32'(e_iss && m_we));
                chk("asic_chip",    32'(asic_chip),    e_iss ? 32'(m_chip) : 32'd0);
                chk("asic_address", 32'(asic_address), e_iss ? 32'(m_aidx) : 32'd0);
                chk("asic_endian",  32'(asic_endian),  32'(e_iss && m_end));
                chk("asic_wdata",   asic_wdata,        e_iss ? m_wd : 32'd0);
                if (e_rv) begin
                    chk("resp_rdata", resp_rdata,      m_rd);
                    chk("resp_err",   32'(resp_err),   32'(m_err));
                end
            end
        end
    end

    // driver: starts and returns at posedge+#1; reports the cycle-1 bus and the response
    task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [6:0] ichip, output logic [7:0] iaddr,
                        output logic iend, output logic iwe, output logic [31:0] iwd);
        int n;
        rd = 32'd0; er = 1'b0; lat = 0;
        ichip = 7'd0; iaddr = 8'd0; iend = 1'b0; iwe = 1'b0; iwd = 32'd0;
        if (hold > 0) resp_ready = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_tests++; n_fail++;
            $display("FAIL req_accept_timeout: got no req_ready expected req_ready within 50 cycles");
            req_valid = 1'b0;
            resp_ready = 1'b1;
            @(posedge clk); #1;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom;
        req_be = 4'($urandom); req_wdata = $urandom;
        @(negedge clk);
        lat = 1;
        ichip = asic_chip; iaddr = asic_address; iend = asic_endian; iwe = asic_we; iwd = asic_wdata;
        while (!resp_valid && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!resp_valid) begin
            n_tests++; n_fail++;
            $display("FAIL resp_timeout: got no resp_valid expected resp_valid within 60 cycles");
            resp_ready = 1'b1;
            @(posedge clk); #1;
            return;
        end
        rd = resp_rdata; er = resp_err;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            resp_ready = 1'b1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] rd, iwd;
        logic        er, iend, iwe;
        int          lat, base, kind;
        logic [6:0]  ichip;
        logic [7:0]  iaddr;
        logic [31:0] err_addr [4];
        logic        err_we [4];
        logic [3:0]  err_be [4];
        logic [31:0] a;

        for (int i = 0; i < 256; i++) rd_mem[i] = $urandom;
        rd_mem[1] = 32'hCAFEF00D;
        rd_mem[2] = 32'h0BADBEEF;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_be = 4'd0;
        req_wdata = 32'd0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_req_ready",  32'(req_ready),  32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_asic_chip",  32'(asic_chip),  32'd0);
        chk("reset_resp_rdata", resp_rdata,      32'd0);
        @(posedge clk); #1;

        // write then read, chip 1
        xact(1'b1, 32'h0000_0404, 4'hF, 32'h1122_3344, 0, rd, er, lat, ichip, iaddr, iend, iwe, iwd);
        chk("wr_iss_we", 32'(iwe), 32'd1);
        chk("wr_iss_chip", 32'(ichip), 32'd1);
        chk("wr_iss_addr", 32'(iaddr), 32'h01);
        chk("wr_iss_endian", 32'(iend), 32'd0);
        chk("wr_iss_wdata", iwd, 32'h1122_3344);
        chk("wr_lat", 32'(lat), 32'd3);
        chk("wr_rdata", rd, 32'd0);
        chk("wr_err", 32'(er), 32'd0);
        xact(1'b0, 32'h0000_0404, 4'h0, 32'd0, 0, rd, er, lat, ichip, iaddr, iend, iwe, iwd);
        chk("rd_iss_we", 32'(iwe), 32'd0);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("rd_rdata", rd, 32'hCAFE_F00D);

        // byte-swapped read, data forwarded unchanged
        xact(1'b0, 32'h0002_0408, 4'h0, 32'd0, 0, rd, er, lat, ichip, iaddr, iend, iwe, iwd);
        chk("end_iss_endian", 32'(iend), 32'd1);
        chk("end_iss_addr", 32'(iaddr), 32'h02);
        chk("end_iss_chip", 32'(ichip), 32'd1);
        chk("end_rdata", rd, 32'h0BAD_BEEF);

        // decode errors: misaligned, chip 0, chip 5, partial write
        err_addr = '{32'h0000_0406, 32'h0000_0004, 32'h0000_1404, 32'h0000_0404};
        err_we   = '{1'b0, 1'b0, 1'b0, 1'b1};
        err_be   = '{4'hF, 4'hF, 4'hF, 4'h3};
        for (int i = 0; i < 4; i++) begin
            xact(err_we[i], err_addr[i], err_be[i], 32'hDEAD_0000 + 32'(i), 0,
                 rd, er, lat, ichip, iaddr, iend, iwe, iwd);
            chk("err_lat", 32'(lat), 32'd1);
            chk("err_flag", 32'(er), 32'd1);
            chk("err_rdata", rd, 32'd0);
            chk("err_chip", 32'(ichip), 32'd0);
        end

        // response backpressure for 10 cycles
        xact(1'b0, 32'h0000_0408, 4'h0, 32'd0, 10, rd, er, lat, ichip, iaddr, iend, iwe, iwd);
        chk("bp_rdata", rd, 32'h0BAD_BEEF);
        @(negedge clk);
        chk("bp_req_ready_after", 32'(req_ready), 32'd1);
        @(posedge clk); #1;

        // reset while a write is on the bus
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h0000_0404; req_be = 4'hF;
        req_wdata = 32'h5555_AAAA;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_issue_we", 32'(asic_we), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_after_we", 32'(asic_we), 32'd0);
        chk("rstmid_after_chip", 32'(asic_chip), 32'd0);
        chk("rstmid_after_resp", 32'(resp_valid), 32'd0);
        @(posedge clk); #1;
        xact(1'b0, 32'h0000_0404, 4'h0, 32'd0, 0, rd, er, lat, ichip, iaddr, iend, iwe, iwd);
        chk("post_rst_rdata", rd, 32'hCAFE_F00D);

        // randomized mix of valid, erroneous and backpressured traffic
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 4);
            a = {14'($urandom), 1'($urandom_range(0, 1)), 7'd1, 8'($urandom), 2'b00};
            if (kind == 3) a = $urandom;
            xact(kind >= 2 ? 1'($urandom_range(0, 1)) : 1'b0, a,
                 kind == 4 ? 4'($urandom) : 4'hF, $urandom, $urandom_range(0, 3),
                 rd, er, lat, ichip, iaddr, iend, iwe, iwd);
        end

        // back-to-back valid reads: one accept every 4 cycles
        base = acc_q.size();
        for (int i = 0; i < 8; i++) begin
            a = {14'($urandom), 1'($urandom_range(0, 1)), 7'd1, 8'($urandom), 2'b00};
            xact(1'b0, a, 4'h0, 32'd0, 0, rd, er, lat, ichip, iaddr, iend, iwe, iwd);
            chk("b2b_lat", 32'(lat), 32'd3);
            chk("b2b_we", 32'(iwe), 32'd0);
            chk("b2b_rdata", rd, rd_mem[a[9:2]]);
        end
        for (int i = base + 1; i < acc_q.size(); i++) begin
            chk("b2b_spacing", 32'(acc_q[i] - acc_q[i-1]), 32'd4);
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
